// File: rtl/osd_dem_uart_rx_pkg.sv
// Shared osd definitions: dii flit type, packet field positions,
// event type code and the UART ingress parser state encoding.
package osd_dem_uart_rx_pkg;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

    localparam logic [3:0] OSD_TYPE_EVENT = 4'b1000;

    localparam int TYPE_MSB = 15;
    localparam int TYPE_LSB = 12;
    localparam int SRC_MSB  = 9;
    localparam int SRC_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FWD_HDR,
        ST_FWD,
        ST_EVT,
        ST_DROP
    } rx_state_e;

    function automatic logic [3:0] flit_type(input logic [15:0] d);
        return d[TYPE_MSB:TYPE_LSB];
    endfunction

endpackage

// File: rtl/osd_dem_uart_rx_if.sv
// dii flit channel with valid/ready handshake.
// master drives the flit, slave returns ready.
interface osd_dem_uart_rx_if;
    import osd_dem_uart_rx_pkg::*;

    dii_flit flit;
    logic    ready;

    modport master (output flit, input ready);
    modport slave  (input flit, output ready);

endinterface

// File: rtl/osd_dem_uart_rx_fifo.sv
// osd_fifo: first-word-fall-through FIFO with full/empty flags.
// Push while full is honoured only together with a pop.
module osd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             pop_en;
    logic             push_en;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_en  = pop_i & ~empty_o;
    assign push_en = push_i & (~full_o | pop_en);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // Pointer next-state.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_en) wr_d = wr_q + 1'b1;
        if (pop_en)  rd_d = rd_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/osd_dem_uart_rx.sv
// DEM UART ingress: event characters go to a FIFO, other packets pass on.
// Macro OSD_DEM_UART_RX_DROP_EN: drop characters on full FIFO instead of stalling.
module osd_dem_uart_rx
    import osd_dem_uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                id_i,
    osd_dem_uart_rx_if.slave          debug_in,
    osd_dem_uart_rx_if.master         reg_out,
    output logic [7:0]                in_char_o,
    output logic                      in_valid_o,
    input  logic                      in_ready_i,
    output logic [7:0]                drop_cnt_o
);

    rx_state_e   state_q;
    logic [15:0] hold_q;
    logic        din_rdy;
    logic        din_acc;
    logic        din_last;
    logic        is_evt;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    dii_flit     rout;

    assign is_evt   = (flit_type(debug_in.flit.data) == OSD_TYPE_EVENT);
    assign din_acc  = debug_in.flit.valid & din_rdy;
    assign din_last = debug_in.flit.last;
    assign push     = (state_q == ST_EVT) & din_acc;
    assign pop      = in_ready_i;

    assign debug_in.ready = din_rdy;
    assign reg_out.flit   = rout;
    assign in_valid_o     = ~empty;

    // Handshake and output decode for the current state.
    always_comb begin
        din_rdy = 1'b0;
        rout    = '0;
        unique case (state_q)
            ST_IDLE: din_rdy = 1'b1;
            ST_HDR:  din_rdy = debug_in.flit.valid & is_evt;
            ST_FWD_HDR: begin
                rout.valid = 1'b1;
                rout.last  = 1'b0;
                rout.data  = hold_q;
            end
            ST_FWD: begin
                rout    = debug_in.flit;
                din_rdy = reg_out.ready;
            end
`ifdef OSD_DEM_UART_RX_DROP_EN
            ST_EVT:  din_rdy = 1'b1;
`else
            ST_EVT:  din_rdy = ~full;
`endif
            ST_DROP: din_rdy = 1'b1;
            default: din_rdy = 1'b0;
        endcase
        if (rst) begin
            din_rdy = 1'b0;
            rout    = '0;
        end
    end

    // Packet parser state machine with flit0 hold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (din_acc) begin
                        hold_q <= debug_in.flit.data;
                        if (!din_last) begin
                            if (debug_in.flit.data[SRC_MSB:SRC_LSB] != id_i)
                                state_q <= ST_DROP;
                            else
                                state_q <= ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    if (din_acc)
                        state_q <= din_last ? ST_IDLE : ST_EVT;
                    else if (debug_in.flit.valid)
                        state_q <= ST_FWD_HDR;
                end
                ST_FWD_HDR: begin
                    if (reg_out.ready) state_q <= ST_FWD;
                end
                ST_FWD, ST_EVT, ST_DROP: begin
                    if (din_acc && din_last) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    osd_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (debug_in.flit.data[7:0]),
        .pop_i   (pop),
        .data_o  (in_char_o),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef OSD_DEM_UART_RX_DROP_EN
    logic [7:0] drop_q, drop_d;

    // Saturating count of characters lost to a full FIFO.
    always_comb begin
        drop_d = drop_q;
        if (push && full && !(pop && !empty) && drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (rst) drop_q <= '0;
        else     drop_q <= drop_d;
    end

    assign drop_cnt_o = drop_q;
`else
    assign drop_cnt_o = '0;
`endif

endmodule

// File: doc/osd_dem_uart_rx.md
# osd_dem_uart_rx

Ingress stage of the UART device-emulation module. It consumes debug packets arriving on the module's `debug_in` port. Event packets carrying host-to-target characters are unpacked into a small character FIFO that drives `in_char`/`in_valid`. All other packets are forwarded unchanged to the control/status interface. It sits between the ring's local port and the DEM UART packetizer and `osd_statctrlif`.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: character FIFO entries; must be a power of two and ≥ 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `id`  in  10  own module address.
- `debug_in`  in  dii_flit  incoming packet stream.
- `debug_in_ready`  out  1  flit accept.
- `reg_out`  out  dii_flit  non-event packets, towards `osd_statctrlif`.
- `reg_out_ready`  in  1  downstream accept.
- `in_char`  out  8  FIFO head character.
- `in_valid`  out  1  FIFO non-empty.
- `in_ready`  in  1  target consumes the head character.
- `drop_cnt`  out  8  dropped-character counter (see Configuration).

## Operation
Packet format:
- flit0: `data` = destination.
- flit1: `data` = {type[3:0], 2'b00, src[9:0]}.
- flit2 onward: payload, last flit marked `last`.
- Event type is 4'b1000. The character is payload `data[7:0]`; bits 15:8 are ignored.

States:
- **IDLE**: `debug_in_ready`=1. On a valid flit, capture it into the hold register.
  - If `last`=1 (single-flit packet), discard it and stay in IDLE.
  - Else, if `data[9:0]`≠`id`, go to DROP.
  - Else go to HDR.
- **HDR**: examine flit1 while it is presented.
  - Type = event: `debug_in_ready`=1. On accept, go to EVT. If flit1 has `last`=1 (no payload), return to IDLE.
  - Otherwise: `debug_in_ready`=0 and flit1 is not consumed. Go to FWD_HDR.
- **FWD_HDR**: `reg_out` = held flit0 with `valid`=1 and `last`=0. `debug_in_ready`=0. When `reg_out_ready`, go to FWD.
- **FWD**: combinational pass-through. `reg_out` = `debug_in` and `debug_in_ready` = `reg_out_ready`. After an accepted flit with `last`, go to IDLE.
- **EVT**: each accepted payload flit pushes `data[7:0]` into the FIFO. `debug_in_ready` = FIFO not full (see Configuration). After an accepted flit with `last`, go to IDLE.
- **DROP**: `debug_in_ready`=1. Flits are consumed and discarded. After `last`, go to IDLE.

Outside FWD_HDR and FWD, `reg_out.valid`=0.

FIFO:
- First-word-fall-through.
- `in_valid` = non-empty; `in_char` = head entry.
- The head is popped on `in_valid & in_ready`.
- A simultaneous push and pop is legal when full and when empty. When full, both the push and the pop occur. When empty, the pop is ignored.

## Timing
- Reset: `state`=IDLE, FIFO empty, `in_valid`=0, `reg_out.valid`=0, `drop_cnt`=0.
- `debug_in_ready` is forced to 0 while `rst`=1. It is 1 in the first cycle after deassert.
- Reset mid-packet discards the partial packet and the FIFO contents. The next flit is treated as flit0.
- Character latency: payload accepted at edge N → `in_valid`=1 with that character in cycle N+1.
- Throughput:
  - One payload character per cycle in EVT when the FIFO is not full.
  - Event packet overhead is 2 cycles (flit0, flit1).
  - A forwarded packet costs 1 bubble cycle (FWD_HDR); each flit after that takes 1 cycle when `reg_out_ready` is held high.
- Handshakes are valid/ready. Once `reg_out.valid` is asserted, `reg_out` data must not change until the flit is accepted; in FWD this depends on the upstream obeying the same rule.

## Configuration
- `OSD_DEM_UART_RX_DROP_EN` defined:
  - In EVT, `debug_in_ready`=1 always.
  - A character arriving while the FIFO is full without a simultaneous pop is discarded.
  - `drop_cnt` increments, saturating at 8'hFF.
  - Prevents a stalled target from blocking the ring.
- Not defined:
  - In EVT, backpressure applies: `debug_in_ready` = !full.
  - No character is ever lost.
  - `drop_cnt` is tied to 0.

## Structure
- `dii_flit` comes from the existing dii package.
- Add to the shared osd package:
  - type code constant `OSD_TYPE_EVENT` = 4'b1000;
  - field positions `TYPE_MSB`/`TYPE_LSB` (15/12) and `SRC_MSB`/`SRC_LSB` (9/0), shared with the packetizer.
- One sub-module: `osd_fifo` (WIDTH=8, DEPTH=`FIFO_DEPTH`), first-word-fall-through, with full/empty flags.
- The parser state machine stays in this module.

## Test plan
- Event packet {0x0005 (`id`=5), 0x8003, 0x0041, 0x0042 `last`}, `in_ready`=1 → `in_char` 0x41 then 0x42 in consecutive cycles. `reg_out.valid` is never asserted.
- Register packet {0x0005, 0x0003, 0x1234 `last`} → `reg_out` carries 0x0005, 0x0003, 0x1234 with `last` on the third flit, with 1 bubble cycle after flit0. The FIFO stays empty.
- Event packet with 6 payload characters, `in_ready`=0, `FIFO_DEPTH`=4:
  - without the macro → `debug_in_ready` drops after 4 characters; releasing `in_ready` yields all 6 characters in order;
  - with the macro → 4 characters are delivered and `drop_cnt`=2.
- Packet with dest 0x0009 (`id`=5) → all flits are consumed. No `reg_out` output and no characters.
- `rst` pulsed after flit1 of an event packet → FIFO empty and `in_valid`=0. The following well-formed packet is parsed correctly.
- Single-flit packet 0x0005 with `last` → discarded. The next packet is parsed normally.
